// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencing controller: branch flush, RAW stall, peripheral freeze
module pipe_ctrl #(
    parameter int FIELD_W   = 8,
    parameter int FLUSH_CYC = 2,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               branchEx,
    input  logic               periReqEx,
    input  logic               periAck,
    input  logic               writeEx,
    input  logic [FIELD_W-1:0] fieldEx,
    input  logic               readId,
    input  logic [FIELD_W-1:0] fieldId,
    output logic               pcEn,
    output logic               reg1En,
    output logic               reg2En,
    output logic               flush1,
    output logic               bubble2,
    output logic               periStart,
    output logic               periTimeout,
    output logic [1:0]         ctrlState,
    output logic [15:0]        stallCnt
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_PERI  = 2'd2;
    localparam logic [1:0] S_HAZ   = 2'd3;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [2:0]      r_flush_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_pend_branch;
    logic            r_peri_to;
    logic [15:0]     r_stall_cnt;

    logic       w_hazard;
    logic       w_to_hit;
    logic       w_release;
    logic [1:0] w_branch_state;
    logic       w_pc_en;
    logic       w_reg1_en;
    logic       w_reg2_en;
    logic       w_flush1;
    logic       w_bubble2;
    logic       w_peri_start;

    assign w_hazard       = readId & writeEx & (fieldId == fieldEx);
    assign w_to_hit       = (r_to_cnt == TO_W'(TIMEOUT));
    assign w_release      = periAck | w_to_hit;
    assign w_branch_state = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (periReqEx)     w_next_state = S_PERI;
                else if (branchEx) w_next_state = w_branch_state;
                else if (w_hazard) w_next_state = S_HAZ;
            end
            S_FLUSH: if (r_flush_cnt <= 3'd1) w_next_state = S_RUN;
            S_PERI:  if (w_release) w_next_state = r_pend_branch ? w_branch_state : S_RUN;
            default: w_next_state = S_RUN;
        endcase
    end

    // Reset forces the squash/hold values combinationally so release is glitch-free.
    always_comb begin
        w_pc_en      = 1'b0;
        w_reg1_en    = 1'b0;
        w_reg2_en    = 1'b0;
        w_flush1     = 1'b1;
        w_bubble2    = 1'b1;
        w_peri_start = 1'b0;
        if (reset) begin
            case (r_state)
                S_RUN: begin
                    if (periReqEx) begin
                        w_peri_start = 1'b1;
                        w_flush1     = 1'b0;
                        w_bubble2    = 1'b0;
                    end else if (branchEx) begin
                        {w_pc_en, w_reg1_en, w_reg2_en} = 3'b111;
                    end else if (w_hazard) begin
                        w_reg2_en = 1'b1;
                        w_flush1  = 1'b0;
                    end else begin
                        {w_pc_en, w_reg1_en, w_reg2_en} = 3'b111;
                        {w_flush1, w_bubble2}           = 2'b00;
                    end
                end
                S_FLUSH: {w_pc_en, w_reg1_en, w_reg2_en} = 3'b111;
                S_PERI: begin
                    if (w_release) begin
                        {w_pc_en, w_reg1_en, w_reg2_en} = 3'b111;
                        {w_flush1, w_bubble2} = {2{r_pend_branch}};
                    end else begin
                        {w_flush1, w_bubble2} = 2'b00;
                    end
                end
                default: begin
                    {w_pc_en, w_reg1_en, w_reg2_en} = 3'b111;
                    {w_flush1, w_bubble2}           = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush_cnt   <= '0;
            r_to_cnt      <= '0;
            r_pend_branch <= 1'b0;
            r_peri_to     <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
            case (r_state)
                S_RUN: begin
                    if (periReqEx) begin
                        r_pend_branch <= branchEx;
                        r_to_cnt      <= '0;
                    end else if (branchEx) begin
                        r_flush_cnt <= FLUSH_INIT;
                    end
                end
                S_FLUSH: r_flush_cnt <= r_flush_cnt - 3'd1;
                S_PERI: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (w_to_hit && !periAck) r_peri_to <= 1'b1;
                    if (w_release && r_pend_branch) r_flush_cnt <= FLUSH_INIT;
                end
                default: ;
            endcase
        end
    end

    assign pcEn        = w_pc_en;
    assign reg1En      = w_reg1_en;
    assign reg2En      = w_reg2_en;
    assign flush1      = w_flush1;
    assign bubble2     = w_bubble2;
    assign periStart   = w_peri_start;
    assign periTimeout = r_peri_to;
    assign ctrlState   = r_state;
    assign stallCnt    = r_stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
    localparam int FIELD_W   = 8;
    localparam int FLUSH_CYC = 2;
    localparam int TIMEOUT   = 255;
    localparam int TO_W      = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic branchEx = 1'b0, periReqEx = 1'b0, periAck = 1'b0, writeEx = 1'b0, readId = 1'b0;
    logic [FIELD_W-1:0] fieldEx = '0, fieldId = '0;
    logic pcEn, reg1En, reg2En, flush1, bubble2, periStart, periTimeout;
    logic [1:0]  ctrlState;
    logic [15:0] stallCnt;

    int n_vec = 0;
    int n_bad = 0;

    // Model: remaining forced bubbles, peripheral wait bookkeeping, stall tally.
    bit m_peri = 0, m_pend = 0, m_haz = 0, m_to = 0;
    int m_wait = 0, m_flush = 0, m_stall = 0;
    bit n_peri, n_pend, n_haz, n_to;
    int n_wait, n_flush, n_stall;

    pipe_ctrl #(.FIELD_W(FIELD_W), .FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .branchEx(branchEx), .periReqEx(periReqEx), .periAck(periAck),
        .writeEx(writeEx), .fieldEx(fieldEx), .readId(readId), .fieldId(fieldId),
        .pcEn(pcEn), .reg1En(reg1En), .reg2En(reg2En), .flush1(flush1), .bubble2(bubble2),
        .periStart(periStart), .periTimeout(periTimeout), .ctrlState(ctrlState), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_peri = 0; m_pend = 0; m_haz = 0; m_to = 0;
        m_wait = 0; m_flush = 0; m_stall = 0;
    endtask

    task automatic eval_and_check();
        bit pc, r1, r2, f1, b2, ps, hz, tmo;
        int st;
        {pc, r1, r2, f1, b2, ps} = 6'b000110;
        st = 0;
        if (!reset) model_reset();
        n_peri = m_peri; n_pend = m_pend; n_haz = m_haz; n_to = m_to;
        n_wait = m_wait; n_flush = m_flush; n_stall = m_stall;
        hz = readId && writeEx && (fieldId == fieldEx);
        if (reset) begin
            if (m_peri) begin
                st = 2;
                tmo = (m_wait == TIMEOUT);
                if (periAck || tmo) begin
                    {pc, r1, r2} = 3'b111;
                    f1 = m_pend; b2 = m_pend;
                    n_peri = 0;
                    if (m_pend) n_flush = FLUSH_CYC - 1;
                    if (!periAck) n_to = 1;
                end else begin
                    f1 = 0; b2 = 0;
                    n_wait = m_wait + 1;
                end
            end else if (m_flush > 0) begin
                st = 1;
                {pc, r1, r2} = 3'b111;
                n_flush = m_flush - 1;
            end else if (m_haz) begin
                st = 3;
                {pc, r1, r2, f1, b2} = 5'b11100;
                n_haz = 0;
            end else if (periReqEx) begin
                {ps, f1, b2} = 3'b100;
                n_peri = 1; n_wait = 0; n_pend = branchEx;
            end else if (branchEx) begin
                {pc, r1, r2} = 3'b111;
                n_flush = FLUSH_CYC - 1;
            end else if (hz) begin
                {r2, f1} = 2'b10;
                n_haz = 1;
            end else begin
                {pc, r1, r2, f1, b2} = 5'b11100;
            end
            if (!pc && m_stall < 65535) n_stall = m_stall + 1;
        end
        check("ctl", {26'd0, pcEn, reg1En, reg2En, flush1, bubble2, periStart},
              {26'd0, pc, r1, r2, f1, b2, ps});
        check("state", {30'd0, ctrlState}, st);
        check("stall", {16'd0, stallCnt}, m_stall);
        check("timeout", {31'd0, periTimeout}, {31'd0, m_to});
    endtask

    task automatic cycle();
        @(negedge clk);
        eval_and_check();
        @(posedge clk);
        if (reset) begin
            m_peri = n_peri; m_pend = n_pend; m_haz = n_haz; m_to = n_to;
            m_wait = n_wait; m_flush = n_flush; m_stall = n_stall;
        end else begin
            model_reset();
        end
        #1;
    endtask

    task automatic idle_inputs();
        branchEx = 0; periReqEx = 0; periAck = 0; writeEx = 0; readId = 0;
        fieldEx = '0; fieldId = '0;
    endtask

    initial begin
        int s0;
        repeat (2) cycle();
        reset = 1;
        cycle();
        check("run_pcen", {31'd0, pcEn}, 32'd1);
        check("run_stall0", {16'd0, stallCnt}, 32'd0);

        // Taken branch
        s0 = stallCnt;
        branchEx = 1; cycle(); branchEx = 0;
        repeat (3) cycle();
        check("branch_nostall", stallCnt - s0, 32'd0);

        // RAW hazard hit, then miss
        s0 = stallCnt;
        readId = 1; writeEx = 1; fieldId = 8'h2A; fieldEx = 8'h2A;
        cycle(); cycle();
        idle_inputs(); cycle();
        check("haz_stall1", stallCnt - s0, 32'd1);
        s0 = stallCnt;
        readId = 1; writeEx = 1; fieldId = 8'h2B; fieldEx = 8'h2A;
        repeat (2) cycle();
        idle_inputs();
        check("haz_miss", stallCnt - s0, 32'd0);

        // Peripheral access with ack, then with pending branch
        s0 = stallCnt;
        periReqEx = 1; cycle(); periReqEx = 0;
        repeat (5) cycle();
        periAck = 1; cycle(); periAck = 0;
        check("peri_stall6", stallCnt - s0, 32'd6);
        repeat (2) cycle();
        periReqEx = 1; branchEx = 1; cycle(); idle_inputs();
        repeat (3) cycle();
        periAck = 1; cycle(); periAck = 0;
        repeat (3) cycle();

        // Timeout, then a stray ack
        periReqEx = 1; cycle(); periReqEx = 0;
        repeat (TIMEOUT + 1) cycle();
        check("to_sticky", {31'd0, periTimeout}, 32'd1);
        periAck = 1; cycle(); periAck = 0;
        repeat (2) cycle();

        // Ack coincident with timeout
        reset = 0; cycle(); reset = 1; cycle();
        periReqEx = 1; cycle(); periReqEx = 0;
        repeat (TIMEOUT) cycle();
        periAck = 1; cycle(); periAck = 0;
        cycle();
        check("to_ack_wins", {31'd0, periTimeout}, 32'd0);

        // Asynchronous reset mid peripheral wait
        periReqEx = 1; cycle(); periReqEx = 0;
        repeat (3) cycle();
        #2 reset = 0; #1;
        check("async_ctl", {26'd0, pcEn, reg1En, reg2En, flush1, bubble2, periStart}, 32'h06);
        check("async_state", {30'd0, ctrlState}, 32'd0);
        check("async_stall", {16'd0, stallCnt}, 32'd0);
        model_reset();
        cycle();
        reset = 1;
        cycle();
        check("no_restart", {31'd0, periStart}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            branchEx  = ($urandom_range(7) == 0);
            periReqEx = ($urandom_range(15) == 0);
            periAck   = ($urandom_range(5) == 0);
            readId    = $urandom_range(1);
            writeEx   = $urandom_range(1);
            fieldEx   = 8'($urandom_range(3));
            fieldId   = 8'($urandom_range(3));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the IL processor.
- Drives the load enables of the PC, pipeline register 1 and pipeline register 2, and the squash (bubble) controls for both registers.
- Handles three cases: taken-branch flush, RAW hazard stall on bit/byte RAM field addresses, and freezing the pipeline during multi-cycle peripheral accesses (UART/SPI/timer) with an ack handshake and timeout.
- Sits beside the pipeline registers; all pipeline registers load only when their enable from this block is high.

Parameters:
- FIELD_W, 8, width of the instruction field (RAM address) compared for hazards
- FLUSH_CYC, 2, bubble cycles inserted after a taken branch (1..7)
- TIMEOUT, 255, cycles waited in PERI_WAIT for periAck before abort
- TO_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- branchEx  in  1  branch resolved taken by the instruction in execute stage
- periReqEx  in  1  execute-stage instruction needs a multi-cycle peripheral access
- periAck  in  1  peripheral access complete (1-cycle pulse)
- writeEx  in  1  execute-stage instruction writes bit/byte RAM
- fieldEx  in  FIELD_W  execute-stage field (RAM address)
- readId  in  1  decode-stage instruction reads bit/byte RAM
- fieldId  in  FIELD_W  decode-stage field
- pcEn  out  1  PC update enable
- reg1En  out  1  pipeline register 1 load enable
- reg2En  out  1  pipeline register 2 load enable
- flush1  out  1  load NOP into pipeline register 1
- bubble2  out  1  load NOP (all enables 0) into pipeline register 2
- periStart  out  1  1-cycle start strobe to peripheral
- periTimeout  out  1  sticky: a peripheral access timed out
- ctrlState  out  2  current state (RUN=0, FLUSH=1, PERI_WAIT=2, HAZ=3)
- stallCnt  out  16  saturating count of cycles with pcEn=0

Behaviour:
- While reset is low:
  - state RUN
  - pcEn=reg1En=reg2En=periStart=0
  - flush1=bubble2=1
  - periTimeout=0, stallCnt=0, timeout counter=0, flush counter=0, pendBranch=0
- Outputs are combinational from state and inputs; state, counters and flags are registered.
- RUN, priority high to low:
  1. periReqEx: periStart=1; pcEn=reg1En=reg2En=0; latch pendBranch=branchEx; clear timeout counter; next state PERI_WAIT.
  2. branchEx: pcEn=1, reg1En=reg2En=1, flush1=1, bubble2=1; FLUSH_CYC=1 stays in RUN, otherwise next state FLUSH with flush counter=FLUSH_CYC-1.
  3. Hazard (readId & writeEx & fieldId==fieldEx): pcEn=reg1En=0, reg2En=1, bubble2=1; next state HAZ.
  4. Otherwise: pcEn=reg1En=reg2En=1, flush1=bubble2=0.
- HAZ: one-cycle recovery with pcEn=reg1En=reg2En=1, no squash; next state RUN. Hazard is not re-evaluated in HAZ, so stall length is exactly 1 cycle.
- FLUSH:
  - pcEn=reg1En=reg2En=1, flush1=bubble2=1.
  - Counter decrements each cycle; at 1, next state RUN.
  - branchEx is ignored in FLUSH because the execute stage holds a bubble.
- PERI_WAIT:
  - pcEn=reg1En=reg2En=0, periStart=0.
  - Timeout counter increments each cycle.
  - periAck: if pendBranch, apply the RUN branch action and go to FLUSH/RUN; else release (all enables 1) and go to RUN.
  - Counter reaches TIMEOUT without periAck: set periTimeout, then act as if periAck was received.
  - periAck and timeout in the same cycle: periAck wins, periTimeout not set.
  - periAck outside PERI_WAIT is ignored.
- stallCnt: +1 on every cycle with pcEn=0 while reset is high; saturates at 0xFFFF with no wrap.
- periTimeout: cleared only by reset.
- Reset asserted mid-PERI_WAIT or mid-FLUSH: immediate return to reset values, with no periStart re-issue after release.

Test Plan:
- Reset release, no requests: pcEn=reg1En=reg2En=1, flush1=bubble2=0, ctrlState=0, stallCnt=0.
- branchEx=1 for 1 cycle (FLUSH_CYC=2): flush1=bubble2=1 for 2 consecutive cycles, pcEn=1 throughout; ctrlState 0→1→0; stallCnt unchanged.
- readId=writeEx=1, fieldId=fieldEx=8'h2A: 1 cycle with pcEn=reg1En=0, bubble2=1, then HAZ, then RUN; stallCnt=1. Repeat with fieldId=8'h2B: no stall.
- periReqEx=1, periAck after 5 cycles: periStart high exactly 1 cycle; enables 0 for 6 cycles; stallCnt=6; resume with no bubble. Repeat with branchEx=1 in the request cycle: after ack, flush1=bubble2=1 for FLUSH_CYC cycles.
- periReqEx with no ack, TIMEOUT=255: release after 255 wait cycles with periTimeout=1 sticky; a later periAck is ignored. Repeat with ack in the same cycle as timeout: periTimeout stays 0.
- Assert reset mid-PERI_WAIT: outputs at reset values immediately; after release, ctrlState=0 and no periStart.
